// File: rtl/pulpemu_spi_host_pkg.sv
// Shared constants, FSM state type and byte-swap helper for the SPI host.
package pulpemu_spi_host_pkg;

  // Command opcodes understood by the PULP SPI slave.
  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_READ  = 8'h0B;

  // Frame lengths: opcode + address + data for writes.
  localparam int WR_BITS = 72;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP,
    RESP
  } state_t;

  // Reverse byte order of a 32-bit word.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/pulpemu_spi_host_clkgen.sv
// SPI clock generator: phase counter over one bit period, rise/fall strobes
// and a registered mode-0 SPI clock that idles low whenever run is low.
module pulpemu_spi_host_clkgen #(
  parameter int CLK_DIV = 2,
  parameter int CW      = $clog2(2 * CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [CW-1:0] phase,
  output logic          rise,
  output logic          fall,
  output logic          spi_clk
);

  // rise: this edge drives spi_clk 0->1; fall: this edge ends the bit period.
  assign rise = run && (phase == CW'(CLK_DIV - 1));
  assign fall = run && (phase == CW'(2 * CLK_DIV - 1));

  // Phase counter and SPI clock register, parked at zero while not shifting.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      phase   <= '0;
      spi_clk <= 1'b0;
    end else begin
      phase <= fall ? '0 : phase + CW'(1);
      if (rise) begin
        spi_clk <= 1'b1;
      end else if (fall) begin
        spi_clk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pulpemu_spi_host.sv
// SPI host bridging a valid/ready memory request port to a PULP SPI slave.
// One frame per request: opcode, address, then write data or dummy bits
// followed by 32 sampled read bits; response is held until consumed.
module pulpemu_spi_host
  import pulpemu_spi_host_pkg::*;
#(
  parameter int CLK_DIV           = 2,
  parameter int DUMMY_CYCLES      = 32,
  parameter int SWITCH_ENDIANNESS = 1
) (
  input  logic        zynq_clk,
  input  logic        zynq_rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  input  logic        rsp_ready_i,
  output logic        spi_clk_o,
  output logic        spi_csn_o,
  output logic        spi_sdo0_o,
  input  logic        spi_sdi0_i
);

  localparam int RD_BITS = WR_BITS + DUMMY_CYCLES;
  localparam int BW      = $clog2(RD_BITS + 1);
  localparam int WW      = $clog2(CLK_DIV + 1);
  localparam int CW      = $clog2(2 * CLK_DIV);

  state_t state, state_next;

  logic          accept, run, rise, fall, last_bit, wait_done;
  logic [CW-1:0] phase;
  logic          we_q;
  logic [BW-1:0] bit_cnt, last_idx;
  logic [WW-1:0] wait_cnt;
  logic [71:0]   tx_q;
  logic [31:0]   rx_q;
  logic          csn_q, rsp_valid_q;
  logic [31:0]   rdata_q;
  logic [31:0]   addr_s, wdata_s, rx_s;

  assign addr_s  = (SWITCH_ENDIANNESS != 0) ? bswap32(req_addr_i)  : req_addr_i;
  assign wdata_s = (SWITCH_ENDIANNESS != 0) ? bswap32(req_wdata_i) : req_wdata_i;
  assign rx_s    = (SWITCH_ENDIANNESS != 0) ? bswap32(rx_q)        : rx_q;

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign run         = (state == SHIFT);
  assign last_idx    = we_q ? BW'(WR_BITS - 1) : BW'(RD_BITS - 1);
  assign last_bit    = fall && (bit_cnt == last_idx);
  assign wait_done   = (wait_cnt == WW'(CLK_DIV - 1));

  // The frame shifts out of the top of tx_q, which drains to zero by the
  // end of every frame, so sdo is quiet whenever chip select is high.
  assign spi_sdo0_o  = tx_q[71];
  assign spi_csn_o   = csn_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;

  pulpemu_spi_host_clkgen #(
    .CLK_DIV (CLK_DIV),
    .CW      (CW)
  ) u_clkgen (
    .clk     (zynq_clk),
    .rst     (zynq_rst),
    .run     (run),
    .phase   (phase),
    .rise    (rise),
    .fall    (fall),
    .spi_clk (spi_clk_o)
  );

  // FSM state register.
  always_ff @(posedge zynq_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (zynq_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (accept)      state_next = SHIFT;
      SHIFT:   if (last_bit)    state_next = HOLD;
      HOLD:    if (wait_done)   state_next = GAP;
      GAP:     if (wait_done)   state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Datapath: request latch, shift registers, counters, chip select, response.
  always_ff @(posedge zynq_clk) begin
    // NOTE: every datapath register is reset so an aborted request leaves nothing stale behind.
    if (zynq_rst) begin
      we_q        <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      csn_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we_i;
            tx_q     <= {(req_we_i ? OPC_WRITE : OPC_READ), addr_s,
                         (req_we_i ? wdata_s : 32'h0)};
            rx_q     <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            csn_q    <= 1'b0;
          end
        end
        SHIFT: begin
          wait_cnt <= '0;
          if (rise) begin
            rx_q <= {rx_q[30:0], spi_sdi0_i};
          end
          if (fall) begin
            tx_q    <= {tx_q[70:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        HOLD: begin
          wait_cnt <= wait_done ? '0 : wait_cnt + WW'(1);
          if (wait_done) begin
            csn_q <= 1'b1;
          end
        end
        GAP: begin
          wait_cnt <= wait_done ? '0 : wait_cnt + WW'(1);
          if (wait_done) begin
            rsp_valid_q <= 1'b1;
            rdata_q     <= we_q ? 32'h0 : rx_s;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Clock generator is parked outside SHIFT; sdo is quiet while deselected.
  assert property (@(posedge zynq_clk) disable iff (zynq_rst) !run |-> (phase == '0));
  assert property (@(posedge zynq_clk) disable iff (zynq_rst) spi_csn_o |-> !spi_sdo0_o);

endmodule

// File: tb/tb_pulpemu_spi_host.sv
// Self-checking bench for pulpemu_spi_host. Two instances: index 0 uses
// CLK_DIV=2/DUMMY=32/swap on, index 1 uses CLK_DIV=1/DUMMY=8/swap off.
// A transaction-level model predicts every output on every cycle.
module tb_pulpemu_spi_host;

  localparam int LIMIT = 3000;

  function automatic int cd_of(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int dm_of(input int i); return (i == 0) ? 32 : 8; endfunction
  function automatic int sw_of(input int i); return (i == 0) ? 1 : 0; endfunction

  function automatic logic [31:0] swap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        req_valid[2];
  logic        req_ready[2];
  logic        req_we[2];
  logic [31:0] req_addr[2];
  logic [31:0] req_wdata[2];
  logic        rsp_valid[2];
  logic [31:0] rsp_rdata[2];
  logic        rsp_ready[2];
  logic        spi_clk[2];
  logic        spi_csn[2];
  logic        spi_sdo[2];
  logic        spi_sdi[2];
  logic [31:0] slave_word[2];

  pulpemu_spi_host #(.CLK_DIV(2), .DUMMY_CYCLES(32), .SWITCH_ENDIANNESS(1)) u_dut0 (
    .zynq_clk(clk), .zynq_rst(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_ready_i(rsp_ready[0]),
    .spi_clk_o(spi_clk[0]), .spi_csn_o(spi_csn[0]), .spi_sdo0_o(spi_sdo[0]),
    .spi_sdi0_i(spi_sdi[0])
  );

  pulpemu_spi_host #(.CLK_DIV(1), .DUMMY_CYCLES(8), .SWITCH_ENDIANNESS(0)) u_dut1 (
    .zynq_clk(clk), .zynq_rst(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_ready_i(rsp_ready[1]),
    .spi_clk_o(spi_clk[1]), .spi_csn_o(spi_csn[1]), .spi_sdo0_o(spi_sdo[1]),
    .spi_sdi0_i(spi_sdi[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave read bit for the k-th SPI rising edge of a read frame.
  function automatic logic slave_bit(input int k, input logic [31:0] w, input int dm);
    int j;
    j = k - 40 - dm;
    if (j >= 0 && j < 32) return w[31 - j];
    return 1'b0;
  endfunction

  // SPI slave models: count rising edges, capture sdo, return read data MSB first.
  for (genvar g = 0; g < 2; g++) begin : g_slave
    int           rise_cnt = 0;
    logic [31:0]  cur_word = '0;
    logic [127:0] cap      = '0;
    always @(posedge spi_clk[g] or negedge spi_csn[g]) begin
      if (spi_clk[g]) begin
        cap      = {cap[126:0], spi_sdo[g]};
        rise_cnt = rise_cnt + 1;
      end else begin
        rise_cnt = 0;
        cap      = '0;
        cur_word = slave_word[g];
      end
    end
    assign spi_sdi[g] = slave_bit(rise_cnt, cur_word, dm_of(g));
  end

  // Transaction model state.
  bit           m_busy[2];
  int           m_t[2];
  int           m_n[2];
  int           m_hdr[2];
  int           m_resp[2];
  logic [135:0] m_frame[2];
  logic [31:0]  m_rdata[2];

  // Model update on each edge from the inputs the DUT sees.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_busy[i] = 1'b0;
      end else if (!m_busy[i]) begin
        if (req_valid[i]) begin
          logic [31:0] a, d;
          a = sw_of(i) ? swap(req_addr[i])  : req_addr[i];
          d = sw_of(i) ? swap(req_wdata[i]) : req_wdata[i];
          m_busy[i]  = 1'b1;
          m_t[i]     = 1;
          m_n[i]     = req_we[i] ? 72 : 72 + dm_of(i);
          m_hdr[i]   = req_we[i] ? 72 : 40 + dm_of(i);
          m_resp[i]  = 1 + 2 * cd_of(i) * (m_n[i] + 1);
          m_frame[i] = req_we[i] ? {8'h02, a, d, 64'h0} : {8'h0B, a, 96'h0};
          m_rdata[i] = req_we[i] ? 32'h0 :
                       (sw_of(i) ? swap(slave_word[i]) : slave_word[i]);
        end
      end else if (m_t[i] >= m_resp[i] && rsp_ready[i]) begin
        m_busy[i] = 1'b0;
      end else begin
        m_t[i]++;
      end
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        string p;
        int cd, t, sh, b;
        p  = $sformatf("d%0d", i);
        cd = cd_of(i);
        if (!m_busy[i]) begin
          check({p, " idle ready"}, req_ready[i], 1'b1);
          check({p, " idle csn"},   spi_csn[i],   1'b1);
          check({p, " idle sclk"},  spi_clk[i],   1'b0);
          check({p, " idle sdo"},   spi_sdo[i],   1'b0);
          check({p, " idle valid"}, rsp_valid[i], 1'b0);
        end else begin
          t  = m_t[i];
          sh = 2 * cd * m_n[i];
          check({p, " busy ready"}, req_ready[i], 1'b0);
          if (t <= sh) begin
            b = (t - 1) / (2 * cd);
            check({p, " shift csn"},   spi_csn[i],   1'b0);
            check({p, " shift sclk"},  spi_clk[i],   (((t - 1) % (2 * cd)) >= cd));
            check({p, " shift valid"}, rsp_valid[i], 1'b0);
            if (b < m_hdr[i]) check({p, " shift sdo"}, spi_sdo[i], m_frame[i][135 - b]);
          end else if (t <= sh + cd) begin
            check({p, " hold csn"},   spi_csn[i],   1'b0);
            check({p, " hold sclk"},  spi_clk[i],   1'b0);
            check({p, " hold valid"}, rsp_valid[i], 1'b0);
          end else begin
            check({p, " post csn"},   spi_csn[i],   1'b1);
            check({p, " post sclk"},  spi_clk[i],   1'b0);
            check({p, " post sdo"},   spi_sdo[i],   1'b0);
            check({p, " rsp valid"},  rsp_valid[i], (t >= m_resp[i]));
            if (t >= m_resp[i]) check({p, " rsp rdata"}, rsp_rdata[i], m_rdata[i]);
          end
        end
      end
    end
  end

  task automatic wait_accept(input int i, output int e);
    int k;
    e = -1;
    for (k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    check($sformatf("d%0d accept within bound", i), (k < LIMIT), 1'b1);
    if (k < LIMIT) begin
      @(posedge clk);
      #1;
      e = cyc;
    end
  endtask

  task automatic finish_resp(input int i, input int delay, output int e_v,
                             output logic [31:0] rd, output int e_hs);
    int k;
    e_v  = -1;
    e_hs = -1;
    rd   = 'x;
    for (k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      if (rsp_valid[i]) break;
    end
    check($sformatf("d%0d response within bound", i), (k < LIMIT), 1'b1);
    if (k < LIMIT) begin
      e_v = cyc;
      rd  = rsp_rdata[i];
      repeat (delay) @(negedge clk);
      rsp_ready[i] = 1'b1;
      @(posedge clk);
      #1;
      e_hs = cyc;
      rsp_ready[i] = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] w);
    req_we[i]     = we;
    req_addr[i]   = a;
    req_wdata[i]  = d;
    slave_word[i] = w;
  endtask

  // Single request; returns latency in cycles (T0 -> rsp_valid) and read data.
  task automatic one_req(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] w, input int delay,
                         output int lat, output logic [31:0] rd);
    int e0, ev, eh;
    set_req(i, we, a, d, w);
    req_valid[i] = 1'b1;
    wait_accept(i, e0);
    req_valid[i] = 1'b0;
    finish_resp(i, delay, ev, rd, eh);
    lat = ev - e0 + 1;
  endtask

  initial begin
    int lat, e0, e1, ev, eh;
    logic [31:0] rd;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; rsp_ready[i] = 1'b0; slave_word[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    check("reset csn",   spi_csn[0],   1'b1);
    check("reset sclk",  spi_clk[0],   1'b0);
    check("reset ready", req_ready[0], 1'b1);
    check("reset valid", rsp_valid[0], 1'b0);
    check("reset rdata", rsp_rdata[0], 32'h0);
    @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Directed write: swapped address/data on the wire, response at T0+293.
    one_req(0, 1'b1, 32'h1C000000, 32'hDEADBEEF, 32'h0, 0, lat, rd);
    check("wr latency", lat, 293);
    check("wr rises",   g_slave[0].rise_cnt, 72);
    check("wr sdo bits", g_slave[0].cap[71:0], 72'h02_0000001C_EFBEADDE);
    check("wr rdata",   rd, 32'h0);

    // Directed read with slow response consumer (10 cycles).
    one_req(0, 1'b0, 32'h1A104000, 32'h0, 32'h12345678, 10, lat, rd);
    check("rd latency", lat, 421);
    check("rd rises",   g_slave[0].rise_cnt, 104);
    check("rd rdata",   rd, 32'h78563412);
    check("rd addr bits", g_slave[0].cap[103:64], 40'h0B_0040101A);

    // Back-to-back: valid stays high, second request accepted right after handshake.
    set_req(0, 1'b1, 32'h00001234, 32'hA5A5_0F0F, 32'h0);
    req_valid[0] = 1'b1;
    wait_accept(0, e0);
    set_req(0, 1'b0, 32'h1C008000, 32'h0, 32'hCAFEF00D);
    finish_resp(0, 0, ev, rd, eh);
    wait_accept(0, e1);
    req_valid[0] = 1'b0;
    check("b2b accept edge", e1 - eh, 1);
    finish_resp(0, 2, ev, rd, eh);
    check("b2b rd rdata", rd, 32'h0DF0FECA);

    // Reset pulse during the address phase: abort, no response.
    set_req(0, 1'b1, 32'hFFFF_0000, 32'h1111_2222, 32'h0);
    req_valid[0] = 1'b1;
    wait_accept(0, e0);
    req_valid[0] = 1'b0;
    repeat (80) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    check("abort csn",   spi_csn[0],   1'b1);
    check("abort sclk",  spi_clk[0],   1'b0);
    check("abort ready", req_ready[0], 1'b1);
    repeat (450) @(posedge clk);
    #1;

    // CLK_DIV=1 read, no byte swap.
    one_req(1, 1'b0, 32'h1A10_2000, 32'h0, 32'h12345678, 0, lat, rd);
    check("cd1 rd latency", lat, 163);
    check("cd1 rd rises",   g_slave[1].rise_cnt, 80);
    check("cd1 rd rdata",   rd, 32'h12345678);

    // Randomized traffic on both instances.
    for (int n = 0; n < 16; n++) begin
      int i;
      i = n % 2;
      one_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), lat, rd);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
